// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - hex keypad operand entry with hold/handshake to a 16-bit unit
//
// Collects up to MAX_DIGITS hex digits into a 16-bit operand, supports CLEAR
// and BACKSPACE, and offers the result downstream on ENTER until accepted.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   key_valid    key_code is valid this cycle
//   key_code     0-15 digit, 16 CLEAR, 17 BACKSPACE, 18 ENTER, 19-31 reserved
//   op_ready     downstream accepts the offered operand
//   operand      operand being entered or held (registered)
//   digit_count  number of digits entered (registered)
//   op_valid     operand offered downstream (state HOLD)
//   key_err      one-cycle pulse for a rejected key (registered)
module operand_entry #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  input  logic        op_ready,
  output logic [15:0] operand,
  output logic [2:0]  digit_count,
  output logic        op_valid,
  output logic        key_err
);

  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_e;

  localparam logic [2:0] MaxCount = 3'(MAX_DIGITS);

  state_e      state_q, state_d;
  logic [15:0] operand_q, operand_d;
  logic [2:0]  count_q, count_d;
  logic        key_err_q, key_err_d;

  logic is_digit, is_clr, is_bs, is_ent, is_rsv;

  assign is_digit = key_valid && (key_code[4] == 1'b0);
  assign is_clr   = key_valid && (key_code == 5'd16);
  assign is_bs    = key_valid && (key_code == 5'd17);
  assign is_ent   = key_valid && (key_code == 5'd18);
  assign is_rsv   = key_valid && (key_code > 5'd18);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      operand_q <= 16'h0000;
      count_q   <= 3'd0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      count_q   <= count_d;
      key_err_q <= key_err_d;
    end
  end

  // Next-state logic; CLEAR overrides everything, including a same-cycle transfer
  always_comb begin
    state_d = state_q;
    if (is_clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_digit)    state_d = ENTRY;
          else if (is_ent) state_d = HOLD;
        end
        ENTRY: begin
          if (is_ent)                          state_d = HOLD;
          else if (is_bs && count_q == 3'd1)   state_d = IDLE;
        end
        HOLD: begin
          if (op_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath / output next values
  always_comb begin
    operand_d = operand_q;
    count_d   = count_q;
    key_err_d = 1'b0;
    if (is_rsv) begin
      key_err_d = 1'b1;
    end else if (is_clr) begin
      operand_d = 16'h0000;
      count_d   = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A fresh digit discards any operand retained from a transfer
          if (is_digit) begin
            operand_d = {12'h000, key_code[3:0]};
            count_d   = 3'd1;
          end
        end
        ENTRY: begin
          if (is_digit) begin
            if (count_q >= MaxCount) begin
              key_err_d = 1'b1;
            end else begin
              operand_d = {operand_q[11:0], key_code[3:0]};
              count_d   = count_q + 3'd1;
            end
          end else if (is_bs) begin
            operand_d = (count_q == 3'd1) ? 16'h0000 : (operand_q >> 4);
            count_d   = count_q - 3'd1;
          end
        end
        HOLD: begin
          if (is_digit || is_bs || is_ent) key_err_d = 1'b1;
        end
        default: ;
      endcase
    end
    // Transfer clears the count but keeps the operand; CLEAR result wins
    if (state_q == HOLD && op_ready && !is_clr) count_d = 3'd0;
  end

  assign operand     = operand_q;
  assign digit_count = count_q;
  assign op_valid    = (state_q == HOLD);
  assign key_err     = key_err_q;

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 4, giving the maximum number of hex digits held; the legal range is 1..4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port key_valid, input, 1 bit: key_code is valid this cycle, one key per asserted cycle.
REQ-005 The block SHALL have port key_code, input, 5 bits, decoded as follows: 0-15 hex digit, 16 CLEAR, 17 BACKSPACE, 18 ENTER, 19-31 reserved.
REQ-006 The block SHALL have port op_ready, input, 1 bit: the downstream 16-bit unit (Not/ALU stage) accepts the operand.
REQ-007 The block SHALL have port operand, output, 16 bits: the operand being entered or held, fed directly to the downstream 16-bit x input.
REQ-008 The block SHALL have port digit_count, output, 3 bits: the number of digits currently entered.
REQ-009 The block SHALL have port op_valid, output, 1 bit: operand is offered downstream.
REQ-010 The block SHALL have port key_err, output, 1 bit: a one-cycle pulse for a rejected key.

Function
REQ-011 The block SHALL implement states IDLE, ENTRY and HOLD; op_valid SHALL be 1 exactly when the state is HOLD.
REQ-012 In IDLE, a digit d SHALL set operand to d, set digit_count to 1 and move to ENTRY on the next edge.
REQ-013 In ENTRY, a digit d with digit_count < MAX_DIGITS SHALL set operand to {operand[11:0], d}, zero-extended to 16 bits, and increment digit_count.
REQ-014 In ENTRY, a digit with digit_count == MAX_DIGITS SHALL leave operand and digit_count unchanged and pulse key_err for one cycle.
REQ-015 In ENTRY, BACKSPACE SHALL set operand to operand >> 4 and decrement digit_count; when the result is 0, it SHALL also move to IDLE with operand 16'h0000.
REQ-016 BACKSPACE in IDLE SHALL be ignored without asserting key_err.
REQ-017 ENTER in IDLE or ENTRY SHALL move to HOLD with operand frozen; ENTER in IDLE SHALL offer the retained operand, which is 0 after reset or CLEAR.
REQ-018 CLEAR in any state SHALL set operand to 0 and digit_count to 0 and move to IDLE; in HOLD this SHALL withdraw op_valid on the next edge.
REQ-019 In HOLD, digits, BACKSPACE and ENTER SHALL be ignored and pulse key_err; operand SHALL be stable while op_valid = 1.
REQ-020 A transfer SHALL occur on an edge where op_valid = 1 and op_ready = 1; the state SHALL then go to IDLE, operand SHALL be retained, and digit_count SHALL go to 0.
REQ-021 When CLEAR and op_ready = 1 occur in the same HOLD cycle, the transfer SHALL count as completed and the CLEAR result SHALL apply, giving IDLE with operand 0.
REQ-022 op_ready SHALL be ignored outside HOLD.
REQ-023 Reserved codes SHALL pulse key_err in every state and change no other state.
REQ-024 A digit in IDLE after a transfer SHALL discard the retained operand and start fresh per REQ-012.
REQ-025 key_valid = 0 SHALL leave all state unchanged and key_code SHALL then be don't-care.
REQ-026 Outputs SHALL be registered, with no combinational path from key_code or op_ready to any output.

Reset
REQ-027 On rst_n = 0 the block SHALL asynchronously set state IDLE, operand 16'h0000, digit_count 0, op_valid 0 and key_err 0.
REQ-028 Reset asserted mid-entry or in HOLD SHALL abandon the operand; no transfer SHALL be reported.
REQ-029 After rst_n is released, the block SHALL accept keys from the first rising edge.

Verification
REQ-030 The bench SHALL cover: keys A,B,C,D,ENTER, op_ready held 0 for 3 cycles then 1 -> operand 16'hABCD, digit_count 4, op_valid high for 4 cycles, then IDLE with operand 16'hABCD.
REQ-031 The bench SHALL cover: keys 1,2,3,4,5 -> operand 16'h1234, key_err pulses exactly once on the fifth key.
REQ-032 The bench SHALL cover: keys 7,F,BACKSPACE,BACKSPACE -> operand 16'h007F, then 16'h0007, then 16'h0000 with state IDLE and digit_count 0.
REQ-033 The bench SHALL cover: keys 3,ENTER, then CLEAR in the same cycle as op_ready = 1 -> op_valid low on the next edge, operand 16'h0000.
REQ-034 The bench SHALL cover: keys 5,6 then rst_n = 0 asynchronously between edges -> operand 16'h0000 and op_valid 0 immediately, with no waiting for clk.
REQ-035 The bench SHALL cover: key_code 25 in ENTRY with operand 16'h0012 -> key_err for one cycle, operand still 16'h0012.
